// File: rtl/key_filter.sv
`timescale 1ns/1ps
// key_filter: 2-flop synchronizer plus a 4-state debounce FSM for an active-low push-button.
// Emits registered press/release pulses, a debounced level and a wrapping press count.
module key_filter #(
  parameter int unsigned CNT_MAX = 999_999,
  parameter int unsigned CNT_W   = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_flag,
  output logic       key_release,
  output logic       key_state,
  output logic [7:0] key_press_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILT_DN = 2'd1;
  localparam logic [1:0] DOWN    = 2'd2;
  localparam logic [1:0] FILT_UP = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             key_s1;
  logic             key_sync;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             flag_nxt;
  logic             release_nxt;
  logic             level_nxt;
  logic [7:0]       press_cnt_nxt;

  // Synchronizer resets to the released level so reset release alone never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_s1   <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_s1   <= key_in;
      key_sync <= key_s1;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    flag_nxt      = 1'b0;
    release_nxt   = 1'b0;
    level_nxt     = key_state;
    press_cnt_nxt = key_press_cnt;
    case (state)
      IDLE: begin
        if (!key_sync) state_nxt = FILT_DN;
      end
      FILT_DN: begin
        if (key_sync) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = DOWN;
          flag_nxt      = 1'b1;
          level_nxt     = 1'b1;
          press_cnt_nxt = key_press_cnt + 8'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (key_sync) state_nxt = FILT_UP;
      end
      FILT_UP: begin
        if (!key_sync) begin
          state_nxt = DOWN;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      key_flag      <= 1'b0;
      key_release   <= 1'b0;
      key_state     <= 1'b0;
      key_press_cnt <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      key_flag      <= flag_nxt;
      key_release   <= release_nxt;
      key_state     <= level_nxt;
      key_press_cnt <= press_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_key_filter.sv
`timescale 1ns/1ps
// Directed bench for key_filter with CNT_MAX=5: press/release latency, bounce rejection,
// async reset mid-operation, press counter wrap and long hold.
module tb_key_filter;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_in  = 1'b1;
  logic       key_flag;
  logic       key_release;
  logic       key_state;
  logic [7:0] key_press_cnt;

  int checks      = 0;
  int failures    = 0;
  int flag_total  = 0;
  int rel_total   = 0;
  int both_total  = 0;

  key_filter #(.CNT_MAX(5), .CNT_W(20)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_flag     (key_flag),
    .key_release  (key_release),
    .key_state    (key_state),
    .key_press_cnt(key_press_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  // Event tally sampled just after each rising edge.
  always @(posedge sys_clk) begin
    #1;
    if (key_flag === 1'b1) flag_total++;
    if (key_release === 1'b1) rel_total++;
    if (key_flag === 1'b1 && key_release === 1'b1) both_total++;
  end

  task automatic do_reset();
    sys_rst = 1'b1;
    key_in  = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    int f0;
    sys_rst = 1'b1;
    key_in  = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++; if (key_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", key_flag); end
    checks++; if (key_release !== 1'b0) begin failures++; $display("FAIL reset_release got=%b exp=0", key_release); end
    checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", key_state); end
    checks++; if (key_press_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", key_press_cnt); end
    sys_rst = 1'b0;
    f0 = flag_total;
    repeat (10) @(negedge sys_clk);
    checks++; if (flag_total - f0 !== 0) begin failures++; $display("FAIL reset_idle_flags got=%0d exp=0", flag_total - f0); end
    checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL reset_idle_state got=%b exp=0", key_state); end
  endtask

  task automatic test_clean_press();
    int   f0;
    int   r0;
    logic exp;
    do_reset();
    f0 = flag_total;
    r0 = rel_total;
    key_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge sys_clk);
      exp = (e == 8);
      checks++; if (key_flag !== exp) begin failures++; $display("FAIL clean_flag edge=%0d got=%b exp=%b", e, key_flag, exp); end
      exp = (e >= 8);
      checks++; if (key_state !== exp) begin failures++; $display("FAIL clean_state edge=%0d got=%b exp=%b", e, key_state, exp); end
    end
    checks++; if (key_press_cnt !== 8'd1) begin failures++; $display("FAIL clean_cnt got=%0d exp=1", key_press_cnt); end
    checks++; if (flag_total - f0 !== 1) begin failures++; $display("FAIL clean_nflags got=%0d exp=1", flag_total - f0); end
    key_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge sys_clk);
      exp = (e == 8);
      checks++; if (key_release !== exp) begin failures++; $display("FAIL clean_release edge=%0d got=%b exp=%b", e, key_release, exp); end
      exp = (e < 8);
      checks++; if (key_state !== exp) begin failures++; $display("FAIL clean_rel_state edge=%0d got=%b exp=%b", e, key_state, exp); end
    end
    checks++; if (rel_total - r0 !== 1) begin failures++; $display("FAIL clean_nrel got=%0d exp=1", rel_total - r0); end
    checks++; if (key_press_cnt !== 8'd1) begin failures++; $display("FAIL clean_cnt_after got=%0d exp=1", key_press_cnt); end
  endtask

  task automatic test_bounce_press();
    int   f0;
    logic exp;
    do_reset();
    f0 = flag_total;
    // low 3, high 1, low 2, high 1, then steady low from edge 8
    for (int e = 1; e <= 20; e++) begin
      key_in = (e == 4 || e == 7);
      @(negedge sys_clk);
      exp = (e == 15);
      checks++; if (key_flag !== exp) begin failures++; $display("FAIL bounce_flag edge=%0d got=%b exp=%b", e, key_flag, exp); end
    end
    checks++; if (flag_total - f0 !== 1) begin failures++; $display("FAIL bounce_nflags got=%0d exp=1", flag_total - f0); end
    checks++; if (key_press_cnt !== 8'd1) begin failures++; $display("FAIL bounce_cnt got=%0d exp=1", key_press_cnt); end
    checks++; if (key_state !== 1'b1) begin failures++; $display("FAIL bounce_state got=%b exp=1", key_state); end
  endtask

  task automatic test_release_bounce();
    int   r0;
    logic exp;
    do_reset();
    key_in = 1'b0;
    repeat (10) @(negedge sys_clk);
    r0 = rel_total;
    // toggles every 2 cycles for 10 cycles (last rise at edge 9), then steady high
    for (int e = 1; e <= 20; e++) begin
      key_in = (e <= 10) ? ((((e - 1) / 2) % 2) == 0) : 1'b1;
      @(negedge sys_clk);
      exp = (e == 16);
      checks++; if (key_release !== exp) begin failures++; $display("FAIL relb_release edge=%0d got=%b exp=%b", e, key_release, exp); end
      exp = (e < 16);
      checks++; if (key_state !== exp) begin failures++; $display("FAIL relb_state edge=%0d got=%b exp=%b", e, key_state, exp); end
    end
    checks++; if (rel_total - r0 !== 1) begin failures++; $display("FAIL relb_nrel got=%0d exp=1", rel_total - r0); end
  endtask

  task automatic test_reset_mid();
    int   r0;
    int   f0;
    logic exp;
    do_reset();
    key_in = 1'b0;
    repeat (10) @(negedge sys_clk);
    key_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    checks++; if (key_press_cnt !== 8'd1) begin failures++; $display("FAIL mid_precnt got=%0d exp=1", key_press_cnt); end
    key_in = 1'b0;
    repeat (6) @(negedge sys_clk);
    r0 = rel_total;
    f0 = flag_total;
    sys_rst = 1'b1;
    #1;
    checks++; if (key_flag !== 1'b0) begin failures++; $display("FAIL mid_flag got=%b exp=0", key_flag); end
    checks++; if (key_release !== 1'b0) begin failures++; $display("FAIL mid_release got=%b exp=0", key_release); end
    checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL mid_state got=%b exp=0", key_state); end
    checks++; if (key_press_cnt !== 8'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", key_press_cnt); end
    repeat (3) @(negedge sys_clk);
    checks++; if (flag_total - f0 !== 0) begin failures++; $display("FAIL mid_rst_flags got=%0d exp=0", flag_total - f0); end
    sys_rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge sys_clk);
      exp = (e == 8);
      checks++; if (key_flag !== exp) begin failures++; $display("FAIL mid_reflag edge=%0d got=%b exp=%b", e, key_flag, exp); end
    end
    checks++; if (key_press_cnt !== 8'd1) begin failures++; $display("FAIL mid_recnt got=%0d exp=1", key_press_cnt); end
    // reset while DOWN: level drops, no release pulse
    sys_rst = 1'b1;
    #1;
    checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL down_rst_state got=%b exp=0", key_state); end
    checks++; if (key_press_cnt !== 8'd0) begin failures++; $display("FAIL down_rst_cnt got=%0d exp=0", key_press_cnt); end
    repeat (2) @(negedge sys_clk);
    key_in  = 1'b1;
    sys_rst = 1'b0;
    repeat (12) @(negedge sys_clk);
    checks++; if (rel_total - r0 !== 0) begin failures++; $display("FAIL mid_nrel got=%0d exp=0", rel_total - r0); end
    checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL mid_final_state got=%b exp=0", key_state); end
  endtask

  task automatic test_counter_wrap();
    int f0;
    int r0;
    int b0;
    do_reset();
    f0 = flag_total;
    r0 = rel_total;
    b0 = both_total;
    for (int i = 0; i < 256; i++) begin
      key_in = 1'b0;
      repeat (9) @(negedge sys_clk);
      checks++; if (key_press_cnt !== 8'((i + 1) % 256)) begin failures++; $display("FAIL wrap_cnt press=%0d got=%0d exp=%0d", i + 1, key_press_cnt, (i + 1) % 256); end
      key_in = 1'b1;
      repeat (9) @(negedge sys_clk);
    end
    checks++; if (flag_total - f0 !== 256) begin failures++; $display("FAIL wrap_nflags got=%0d exp=256", flag_total - f0); end
    checks++; if (rel_total - r0 !== 256) begin failures++; $display("FAIL wrap_nrel got=%0d exp=256", rel_total - r0); end
    checks++; if (both_total - b0 !== 0) begin failures++; $display("FAIL wrap_overlap got=%0d exp=0", both_total - b0); end
    checks++; if (key_press_cnt !== 8'd0) begin failures++; $display("FAIL wrap_final got=%0d exp=0", key_press_cnt); end
  endtask

  task automatic test_long_hold();
    int f0;
    int r0;
    do_reset();
    f0 = flag_total;
    r0 = rel_total;
    key_in = 1'b0;
    repeat (1000) @(negedge sys_clk);
    checks++; if (flag_total - f0 !== 1) begin failures++; $display("FAIL hold_nflags got=%0d exp=1", flag_total - f0); end
    checks++; if (rel_total - r0 !== 0) begin failures++; $display("FAIL hold_nrel got=%0d exp=0", rel_total - r0); end
    checks++; if (key_state !== 1'b1) begin failures++; $display("FAIL hold_state got=%b exp=1", key_state); end
    checks++; if (key_press_cnt !== 8'd1) begin failures++; $display("FAIL hold_cnt got=%0d exp=1", key_press_cnt); end
    key_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    checks++; if (rel_total - r0 !== 1) begin failures++; $display("FAIL hold_rel got=%0d exp=1", rel_total - r0); end
    checks++; if (key_state !== 1'b0) begin failures++; $display("FAIL hold_rel_state got=%b exp=0", key_state); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_release_bounce();
    test_reset_mid();
    test_counter_wrap();
    test_long_hold();
    checks++; if (both_total !== 0) begin failures++; $display("FAIL global_overlap got=%0d exp=0", both_total); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
